// File: rtl/m_dbus_ctrl_if.sv
// M-stage data-bus interface: request/ack handshake with byte enables.
interface m_dbus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/m_dbus_ctrl.sv
// M-stage data-bus controller: alignment/range checks, AdEL/AdES, req/ack bus
// master with byte enables, pipeline stall and load extension.
// Optional feature macro: DBUS_TIMEOUT_EN (bus watchdog, exception code 7).
module m_dbus_ctrl #(
  parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
  parameter logic [31:0] TMR0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TMR1_BASE = 32'h0000_7F10
`ifdef DBUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  op_i,
  input  logic [4:0]  exc_i,
  input  logic        ov_i,
  m_dbus_ctrl_if.master dbus,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  exc_o
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        is_ld, is_st, op_valid, is_word, is_half, is_byte;
  logic        in_tmr, chk_fail, go;
  logic        issue, bus_end, tmo_hit;
  logic [3:0]  be_c;
  logic [31:0] wd_c, ld_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Op decode and address legality checks
  always_comb begin
    is_ld   = (op_i >= OP_LW) && (op_i <= OP_LBU);
    is_st   = (op_i >= OP_SW) && (op_i <= OP_SB);
    op_valid = is_ld || is_st;
    is_word = (op_i == OP_LW) || (op_i == OP_SW);
    is_half = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
    is_byte = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
    in_tmr  = ((addr_i >= TMR0_BASE) && (addr_i <= TMR0_BASE + 32'd11)) ||
              ((addr_i >= TMR1_BASE) && (addr_i <= TMR1_BASE + 32'd11));
    chk_fail = op_valid && (
                 (is_word && (addr_i[1:0] != 2'b00)) ||
                 (is_half && addr_i[0]) ||
                 ov_i ||
                 (!(addr_i <= DM_TOP) && !in_tmr) ||
                 (in_tmr && !is_word) ||
                 (is_st && ((addr_i == TMR0_BASE + 32'd8) || (addr_i == TMR1_BASE + 32'd8))));
  end

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_q;

  assign tmo_hit = ((state_q == S_BUSY) || (state_q == S_DRAIN)) &&
                   (tmo_cnt == 8'(TIMEOUT_CYC));

  // Watchdog counter over the outstanding transaction, plus sticky timeout flag for DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      if ((state_q == S_BUSY) || (state_q == S_DRAIN)) tmo_cnt <= tmo_cnt + 8'd1;
      else                                             tmo_cnt <= 8'd0;
      if (state_q == S_BUSY && tmo_hit && !dbus.bus_ack && !req) tmo_q <= 1'b1;
      else if (state_q == S_DONE)                                 tmo_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Exception code: upstream code wins, then timeout, then address check
  always_comb begin
    exc_o = 5'd0;
    if (exc_i != 5'd0)  exc_o = exc_i;
`ifdef DBUS_TIMEOUT_EN
    else if (tmo_q)     exc_o = 5'd7;
`endif
    else if (chk_fail)  exc_o = is_st ? EXC_ADES : EXC_ADEL;
  end

  assign go = op_valid && (exc_o == 5'd0) && !req;

  // Byte enables, lane-replicated store data and extended load data
  always_comb begin
    be_c = 4'b1111;
    wd_c = wdata_i;
    if (is_half) begin
      be_c = addr_i[1] ? 4'b1100 : 4'b0011;
      wd_c = {2{wdata_i[15:0]}};
    end else if (is_byte) begin
      be_c = 4'b0001 << addr_i[1:0];
      wd_c = {4{wdata_i[7:0]}};
    end
    lane_b = dbus.bus_rdata[{addr_i[1:0], 3'b000} +: 8];
    lane_h = addr_i[1] ? dbus.bus_rdata[31:16] : dbus.bus_rdata[15:0];
    case (op_i)
      OP_LB:   ld_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_ext = {24'd0, lane_b};
      OP_LH:   ld_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_ext = {16'd0, lane_h};
      default: ld_ext = dbus.bus_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, stall and bus control strobes
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    issue   = 1'b0;
    bus_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = go;
        if (go) begin
          issue   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (dbus.bus_ack || tmo_hit) begin
          bus_end = 1'b1;
          // A flush coinciding with completion discards the result
          state_d = req ? S_IDLE : S_DONE;
        end else if (req) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_DRAIN: begin
        stall_o = op_valid;
        if (dbus.bus_ack || tmo_hit) begin
          bus_end = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q == S_BUSY) || (state_q == S_DRAIN);

  // Bus request registers and load result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbus.bus_req   <= 1'b0;
      dbus.bus_we    <= 1'b0;
      dbus.bus_addr  <= 32'd0;
      dbus.bus_be    <= 4'd0;
      dbus.bus_wdata <= 32'd0;
      rdata_o        <= 32'd0;
    end else begin
      if (issue) begin
        dbus.bus_req   <= 1'b1;
        dbus.bus_we    <= is_st;
        dbus.bus_addr  <= {addr_i[31:2], 2'b00};
        dbus.bus_be    <= be_c;
        dbus.bus_wdata <= wd_c;
      end else if (bus_end) begin
        dbus.bus_req   <= 1'b0;
      end
      if (state_q == S_BUSY && bus_end && !req)
        rdata_o <= (dbus.bus_ack && is_ld) ? ld_ext : 32'd0;
    end
  end

endmodule
